// File: rtl/nonce_uart_serializer.sv
// Buffers 32-bit golden nonces and streams them, byte by byte, to a UART transmitter.
// Optional macro NONCE_ASCII_HEX_EN: send 8 uppercase hex digits plus CR LF instead of 4 raw bytes.
module nonce_uart_serializer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        nonce_valid,
   input  logic [31:0] nonce,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        fifo_full,
   output logic [7:0]  drop_count,
   output logic        idle
);

`ifdef NONCE_ASCII_HEX_EN
   localparam logic [3:0] LAST  = 4'd9;
   localparam int         SHIFT = 4;
`else
   localparam logic [3:0] LAST  = 4'd3;
   localparam int         SHIFT = 8;
`endif

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO
   } state_t;

   logic [31:0]     mem_q [DEPTH];
   logic [31:0]     mem_d [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0] count_q, count_d;
   logic [7:0]      drop_q, drop_d;

   state_t          state_q, state_d;
   logic [31:0]     shreg_q, shreg_d;
   logic [3:0]      byte_idx_q, byte_idx_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_start_q, tx_start_d;

   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            drop;
   logic [31:0]     head;
   logic [31:0]     sr_adv;
   logic [3:0]      idx_adv;
   logic [7:0]      head_byte;
   logic [7:0]      adv_byte;

   assign head    = mem_q[rd_ptr_q];
   assign sr_adv  = shreg_q << SHIFT;
   assign idx_adv = byte_idx_q + 4'd1;

`ifdef NONCE_ASCII_HEX_EN
   function automatic logic [7:0] hex_char(input logic [3:0] n);
      logic [7:0] c;
      if (n < 4'd10) begin
         c = {4'h3, n};
      end else begin
         c = 8'h37 + {4'h0, n};
      end
      return c;
   endfunction

   // Byte encoder: hex digit from the top nibble, then CR and LF trailer.
   always_comb begin
      head_byte = hex_char(head[31:28]);
      adv_byte  = hex_char(sr_adv[31:28]);
      if (idx_adv == 4'd8) begin
         adv_byte = 8'h0D;
      end else if (idx_adv == 4'd9) begin
         adv_byte = 8'h0A;
      end
   end
`else
   // Byte encoder: raw top byte of the shift register.
   always_comb begin
      head_byte = head[31:24];
      adv_byte  = sr_adv[31:24];
   end
`endif

   // FIFO bookkeeping; fullness comes from the count at the start of the cycle.
   always_comb begin
      full     = (count_q == FULL_CNT);
      empty    = (count_q == '0);
      push     = nonce_valid & ~full;
      drop     = nonce_valid & full;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      if (push) begin
         mem_d[wr_ptr_q] = nonce;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (drop && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // Byte sequencer: load a nonce, then pace each byte through the start/busy handshake.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      byte_idx_d = byte_idx_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      pop        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shreg_d    = head;
               byte_idx_d = 4'd0;
               tx_data_d  = head_byte;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               state_d    = S_WAIT_HI;
            end
         end
         S_WAIT_HI: begin
            if (tx_busy) begin
               state_d = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            if (!tx_busy) begin
               if (byte_idx_q == LAST) begin
                  state_d = S_IDLE;
               end else begin
                  byte_idx_d = idx_adv;
                  shreg_d    = sr_adv;
                  tx_data_d  = adv_byte;
                  state_d    = S_START;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_q     <= 8'h00;
         state_q    <= S_IDLE;
         shreg_q    <= 32'h0;
         byte_idx_q <= 4'd0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_q     <= drop_d;
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         byte_idx_q <= byte_idx_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
      end
   end

   // FIFO storage; contents are don't-care until the count covers them.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign fifo_full  = full;
   assign drop_count = drop_q;
   assign idle       = (state_q == S_IDLE) & empty;

endmodule
